aclk_alarm_bank: RTL and testbench

- Parametrised successor of the single alarm-time register: NUM_ALARMS independently loadable alarm slots, each with an enable bit and its own ring/snooze state machine.
- Compares every enabled slot against the current clock time on each minute tick and drives a single registered alarm output plus the ringing slot index.
- Sits between the key/load controller and the display/sounder logic of the alarm clock.

---
 rtl/aclk_pkg.sv | 19 +
 rtl/aclk_alarm_slot.sv | 100 ++++++++++
 rtl/aclk_alarm_bank.sv | 110 +++++++++++
 tb/tb_aclk_alarm_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types for the alarm bank: per-slot state encoding and the packed BCD alarm time.
package aclk_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZED
    } slot_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hr;
        logic [DIGIT_W-1:0] ls_hr;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } alarm_time_t;

endpackage

// File: rtl/aclk_alarm_slot.sv
// One alarm slot: stored time/enable, time comparator, ring/snooze FSM and its minute down-counter.
module aclk_alarm_slot
    import aclk_pkg::*;
#(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        load_enable,
    input  alarm_time_t load_time,
    input  alarm_time_t cur_time,
    input  logic        minute_tick,
    input  logic        stop_alarm,
    input  logic        snooze_req,
    output alarm_time_t stored_time,
    output logic        enable,
    output logic        ringing_nxt,
    output logic        snoozed_nxt
);

    slot_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        match;

    assign match = minute_tick && enable && (cur_time == stored_time);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d = RINGING;
                        cnt_d   = 4'(RING_TIMEOUT);
                    end
                end
                RINGING: begin
                    if (stop_alarm) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (snooze_req) begin
                        state_d = SNOOZED;
                        cnt_d   = 4'(SNOOZE_MIN);
                    end else if (minute_tick) begin
                        if (cnt_q == 4'd1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (stop_alarm) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (minute_tick) begin
                        if (cnt_q == 4'd1) begin
                            state_d = RINGING;
                            cnt_d   = 4'(RING_TIMEOUT);
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stored_time <= '0;
            enable      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                stored_time <= load_time;
                enable      <= load_enable;
            end
        end
    end

    // Next-state flags let the bank register its outputs on the same edge as the transition.
    assign ringing_nxt = (state_d == RINGING);
    assign snoozed_nxt = (state_d == SNOOZED);

endmodule

// File: rtl/aclk_alarm_bank.sv
// Bank of NUM_ALARMS alarm slots with load decode, lowest-index ring encoder and registered readback.
module aclk_alarm_bank
    import aclk_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_new_alarm,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             load_enable,
    input  logic [3:0]       new_alarm_ms_hr,
    input  logic [3:0]       new_alarm_ls_hr,
    input  logic [3:0]       new_alarm_ms_min,
    input  logic [3:0]       new_alarm_ls_min,
    input  logic [3:0]       cur_ms_hr,
    input  logic [3:0]       cur_ls_hr,
    input  logic [3:0]       cur_ms_min,
    input  logic [3:0]       cur_ls_min,
    input  logic             minute_tick,
    input  logic             stop_alarm,
    input  logic             snooze_req,
    output logic             alarm,
    output logic [IDX_W-1:0] alarm_id,
    output logic             snooze_active,
    output logic [3:0]       rd_ms_hr,
    output logic [3:0]       rd_ls_hr,
    output logic [3:0]       rd_ms_min,
    output logic [3:0]       rd_ls_min,
    output logic             rd_enable
);

    alarm_time_t     new_time, cur_time;
    alarm_time_t     slot_time [NUM_ALARMS];
    logic            slot_en   [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] ring_nxt, snz_nxt;

    assign new_time = '{new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = '{cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
        aclk_alarm_slot #(
            .SNOOZE_MIN  (SNOOZE_MIN),
            .RING_TIMEOUT(RING_TIMEOUT)
        ) u_slot (
            .clock      (clock),
            .reset_n    (reset_n),
            .load       (load_new_alarm && (load_idx == IDX_W'(g))),
            .load_enable(load_enable),
            .load_time  (new_time),
            .cur_time   (cur_time),
            .minute_tick(minute_tick),
            .stop_alarm (stop_alarm),
            .snooze_req (snooze_req),
            .stored_time(slot_time[g]),
            .enable     (slot_en[g]),
            .ringing_nxt(ring_nxt[g]),
            .snoozed_nxt(snz_nxt[g])
        );
    end

    logic [IDX_W-1:0] id_d;
    alarm_time_t      rd_time_d;
    logic             rd_en_d;

    always_comb begin
        id_d = '0;
        for (int unsigned i = NUM_ALARMS; i > 0; i--) begin
            if (ring_nxt[i-1]) id_d = IDX_W'(i-1);
        end
    end

    // Decoding by comparison leaves out-of-range indices reading as zero.
    always_comb begin
        rd_time_d = '0;
        rd_en_d   = 1'b0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (load_idx == IDX_W'(i)) begin
                rd_time_d = slot_time[i];
                rd_en_d   = slot_en[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alarm         <= 1'b0;
            alarm_id      <= '0;
            snooze_active <= 1'b0;
            rd_ms_hr      <= '0;
            rd_ls_hr      <= '0;
            rd_ms_min     <= '0;
            rd_ls_min     <= '0;
            rd_enable     <= 1'b0;
        end else begin
            alarm         <= |ring_nxt;
            alarm_id      <= id_d;
            snooze_active <= |snz_nxt;
            rd_ms_hr      <= rd_time_d.ms_hr;
            rd_ls_hr      <= rd_time_d.ls_hr;
            rd_ms_min     <= rd_time_d.ms_min;
            rd_ls_min     <= rd_time_d.ls_min;
            rd_enable     <= rd_en_d;
        end
    end

endmodule

// File: tb/tb_aclk_alarm_bank.sv
// Directed table-driven bench for aclk_alarm_bank (4 slots, snooze 5, timeout 10).
module tb_aclk_alarm_bank;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_new_alarm = 1'b0;
    logic [1:0] load_idx = '0;
    logic       load_enable = 1'b0;
    logic [15:0] new_t = '0;
    logic [15:0] cur_t = '0;
    logic       minute_tick = 1'b0;
    logic       stop_alarm = 1'b0;
    logic       snooze_req = 1'b0;
    logic       alarm;
    logic [1:0] alarm_id;
    logic       snooze_active;
    logic [3:0] rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min;
    logic       rd_enable;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    aclk_alarm_bank #(
        .NUM_ALARMS  (4),
        .SNOOZE_MIN  (5),
        .RING_TIMEOUT(10)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .load_new_alarm  (load_new_alarm),
        .load_idx        (load_idx),
        .load_enable     (load_enable),
        .new_alarm_ms_hr (new_t[15:12]),
        .new_alarm_ls_hr (new_t[11:8]),
        .new_alarm_ms_min(new_t[7:4]),
        .new_alarm_ls_min(new_t[3:0]),
        .cur_ms_hr       (cur_t[15:12]),
        .cur_ls_hr       (cur_t[11:8]),
        .cur_ms_min      (cur_t[7:4]),
        .cur_ls_min      (cur_t[3:0]),
        .minute_tick     (minute_tick),
        .stop_alarm      (stop_alarm),
        .snooze_req      (snooze_req),
        .alarm           (alarm),
        .alarm_id        (alarm_id),
        .snooze_active   (snooze_active),
        .rd_ms_hr        (rd_ms_hr),
        .rd_ls_hr        (rd_ls_hr),
        .rd_ms_min       (rd_ms_min),
        .rd_ls_min       (rd_ls_min),
        .rd_enable       (rd_enable)
    );

    typedef struct {
        logic        ld;
        logic [1:0]  idx;
        logic        en;
        logic [15:0] t;
        logic [15:0] cur;
        logic        tick;
        logic        stop;
        logic        snz;
        logic        ea;
        logic [1:0]  eid;
        logic        es;
        logic        chk;
        logic [15:0] erd;
        logic        eren;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [1:0] idx, logic en, logic [15:0] t,
                                logic [15:0] cur, logic tick, logic stop, logic snz,
                                logic ea, logic [1:0] eid, logic es,
                                logic chk, logic [15:0] erd, logic eren);
        vec_t v;
        v.ld = ld; v.idx = idx; v.en = en; v.t = t; v.cur = cur;
        v.tick = tick; v.stop = stop; v.snz = snz;
        v.ea = ea; v.eid = eid; v.es = es;
        v.chk = chk; v.erd = erd; v.eren = eren;
        return v;
    endfunction

    function automatic vec_t ld_v(logic [1:0] idx, logic en, logic [15:0] t,
                                  logic [15:0] erd, logic eren);
        return mk(1, idx, en, t, 16'h0, 0, 0, 0, 0, 0, 0, 1, erd, eren);
    endfunction

    function automatic vec_t rd_v(logic [1:0] idx, logic [15:0] erd, logic eren,
                                  logic ea, logic [1:0] eid, logic es);
        return mk(0, idx, 0, 16'h0, 16'h0, 0, 0, 0, ea, eid, es, 1, erd, eren);
    endfunction

    function automatic vec_t tk_v(logic [15:0] cur, logic ea, logic [1:0] eid, logic es);
        return mk(0, 0, 0, 16'h0, cur, 1, 0, 0, ea, eid, es, 0, 16'h0, 0);
    endfunction

    function automatic vec_t ev_v(logic stop, logic snz, logic ea, logic [1:0] eid, logic es);
        return mk(0, 0, 0, 16'h0, 16'h0, 0, stop, snz, ea, eid, es, 0, 16'h0, 0);
    endfunction

    task automatic check1(string name, int n, logic [15:0] act, logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic check_rd(string tag, int n, logic [15:0] erd, logic eren);
        check1({tag, "_rd_time"}, n, {rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min}, erd);
        check1({tag, "_rd_enable"}, n, {15'd0, rd_enable}, {15'd0, eren});
    endtask

    task automatic apply(vec_t v, int n);
        @(negedge clock);
        load_new_alarm = v.ld;
        load_idx       = v.idx;
        load_enable    = v.en;
        new_t          = v.t;
        cur_t          = v.cur;
        minute_tick    = v.tick;
        stop_alarm     = v.stop;
        snooze_req     = v.snz;
        @(posedge clock);
        #1;
        check1("alarm", n, {15'd0, alarm}, {15'd0, v.ea});
        check1("alarm_id", n, {14'd0, alarm_id}, {14'd0, v.eid});
        check1("snooze_active", n, {15'd0, snooze_active}, {15'd0, v.es});
        if (v.chk) check_rd("vec", n, v.erd, v.eren);
    endtask

    task automatic idle_inputs();
        load_new_alarm = 0; load_enable = 0; minute_tick = 0;
        stop_alarm = 0; snooze_req = 0; load_idx = 0; new_t = '0; cur_t = '0;
    endtask

    initial begin
        // Basic ring, lowest-index priority, stop.
        tbl.push_back(rd_v(0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(ld_v(2, 1, 16'h0730, 16'h0000, 0));
        tbl.push_back(rd_v(2, 16'h0730, 1, 0, 0, 0));
        tbl.push_back(tk_v(16'h0730, 1, 2, 0));
        tbl.push_back(tk_v(16'h0731, 1, 2, 0));
        tbl.push_back(ev_v(1, 0, 0, 0, 0));
        tbl.push_back(ld_v(1, 1, 16'h0600, 16'h0000, 0));
        tbl.push_back(ld_v(3, 1, 16'h0600, 16'h0000, 0));
        tbl.push_back(tk_v(16'h0600, 1, 1, 0));
        tbl.push_back(ev_v(1, 0, 0, 0, 0));
        // Snooze: 4 ticks stay snoozed, 5th re-rings.
        tbl.push_back(ld_v(0, 1, 16'h0800, 16'h0000, 0));
        tbl.push_back(tk_v(16'h0800, 1, 0, 0));
        tbl.push_back(ev_v(0, 1, 0, 0, 1));
        for (int i = 1; i <= 4; i++) tbl.push_back(tk_v(16'h0800 + 16'(i), 0, 0, 1));
        tbl.push_back(tk_v(16'h0805, 1, 0, 0));
        // Ring timeout: 9 ticks still ringing, 10th stops.
        for (int i = 0; i < 9; i++) tbl.push_back(tk_v(16'h0900, 1, 0, 0));
        tbl.push_back(tk_v(16'h0900, 0, 0, 0));
        // Snooze with nothing ringing is a no-op; stop clears snooze.
        tbl.push_back(tk_v(16'h0800, 1, 0, 0));
        tbl.push_back(ev_v(0, 1, 0, 0, 1));
        tbl.push_back(ev_v(0, 1, 0, 0, 1));
        tbl.push_back(ev_v(1, 0, 0, 0, 0));
        // Disable slot3; load slot1 on its matching tick.
        tbl.push_back(ld_v(3, 0, 16'h0600, 16'h0600, 1));
        tbl.push_back(mk(1, 1, 1, 16'h0600, 16'h0600, 1, 0, 0, 0, 0, 0, 1, 16'h0600, 1));
        tbl.push_back(tk_v(16'h0600, 1, 1, 0));
        tbl.push_back(ev_v(1, 0, 0, 0, 0));
        // Stop coincident with a new match.
        tbl.push_back(tk_v(16'h0800, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0730, 1, 1, 0, 1, 2, 0, 0, 16'h0, 0));
        tbl.push_back(ev_v(1, 0, 0, 0, 0));
        // Clearing enable via load cancels ringing.
        tbl.push_back(tk_v(16'h0800, 1, 0, 0));
        tbl.push_back(ld_v(0, 0, 16'h0800, 16'h0800, 1));
        tbl.push_back(rd_v(0, 16'h0800, 0, 0, 0, 0));
        tbl.push_back(ld_v(0, 1, 16'h0800, 16'h0800, 0));
        tbl.push_back(tk_v(16'h0800, 1, 0, 0));

        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        check1("reset_alarm", 0, {15'd0, alarm}, 16'd0);
        check1("reset_alarm_id", 0, {14'd0, alarm_id}, 16'd0);
        check1("reset_snooze", 0, {15'd0, snooze_active}, 16'd0);
        check_rd("reset", 0, 16'h0000, 0);
        @(negedge clock);
        reset_n = 1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Asynchronous reset while slot0 rings.
        @(negedge clock);
        idle_inputs();
        #2;
        reset_n = 0;
        #1;
        check1("midreset_alarm", 100, {15'd0, alarm}, 16'd0);
        check1("midreset_alarm_id", 100, {14'd0, alarm_id}, 16'd0);
        check_rd("midreset", 100, 16'h0000, 0);
        @(negedge clock);
        reset_n = 1;
        apply(rd_v(0, 16'h0000, 0, 0, 0, 0), 101);
        apply(tk_v(16'h0800, 0, 0, 0), 102);
        apply(ld_v(0, 1, 16'h0800, 16'h0000, 0), 103);
        apply(tk_v(16'h0800, 1, 0, 0), 104);

        @(negedge clock);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
